// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: opcode encodings and the
// serial transmitter state type.
package alu_pkg;

   localparam logic [1:0] ADD = 2'b00;
   localparam logic [1:0] SUB = 2'b01;
   localparam logic [1:0] MUL = 2'b10;
   localparam logic [1:0] DIV = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

endpackage

// File: rtl/alu_result_uart_tx_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens on the same edge.
module sync_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic [DATA_W-1:0]             din,
   output logic [DATA_W-1:0]             dout,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_result_uart_tx.sv
// Captures ALU result bytes into a FIFO and sends each one as an 8N1 frame
// on a registered, idle-high serial line.
module alu_result_uart_tx
   import alu_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 4,
   parameter int DATA_W       = 8
) (
   input  logic                         CLK,
   input  logic                         rst,
   input  logic [DATA_W-1:0]            alu_out,
   input  logic                         capture,
   output logic                         tx,
   output logic                         busy,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                         overflow
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

   tx_state_t         state;
   logic [TW-1:0]     timer;
   logic [2:0]        bit_idx;
   logic [DATA_W-1:0] shift;
   logic [DATA_W-1:0] head;
   logic              bit_end;
   logic              pop;
   logic              full;
   logic              empty;
   logic              drop;

   assign bit_end = (timer == T_LAST);
   assign pop     = !empty && ((state == IDLE) || (state == STOP && bit_end));
   assign drop    = capture && full && !pop;
   assign busy    = (state != IDLE) || !empty;

   sync_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst   (rst),
      .push  (capture),
      .pop   (pop),
      .din   (alu_out),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   always_ff @(posedge CLK) begin
      if (!rst) begin
         state    <= IDLE;
         tx       <= 1'b1;
         timer    <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         overflow <= 1'b0;
      end else begin
         if (drop) begin
            overflow <= 1'b1;
         end
         timer <= bit_end ? '0 : timer + 1'b1;
         case (state)
            IDLE: begin
               timer <= '0;
               tx    <= 1'b1;
               if (pop) begin
                  shift <= head;
                  tx    <= 1'b0;
                  state <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  state   <= DATA;
                  bit_idx <= '0;
                  tx      <= shift[0];
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     tx    <= 1'b1;
                  end else begin
                     // next bit is presented directly from shift[1] so tx stays registered
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (pop) begin
                     shift <= head;
                     tx    <= 1'b0;
                     state <= START;
                  end else begin
                     state <= IDLE;
                     tx    <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Directed bench for alu_result_uart_tx: a line monitor decodes every frame
// and compares it with the bytes queued by the stimulus process.
module tb_alu_result_uart_tx;

   logic       CLK = 1'b0;
   logic       rst;
   logic [7:0] alu_out;
   logic       capture;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_count;
   logic       overflow;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] exp_q[$];

   alu_result_uart_tx #(
      .CLKS_PER_BIT (4),
      .FIFO_DEPTH   (4),
      .DATA_W       (8)
   ) dut (
      .CLK        (CLK),
      .rst        (rst),
      .alu_out    (alu_out),
      .capture    (capture),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst     = 1'b0;
      capture = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      rst = 1'b1;
      exp_q.delete();
      @(negedge CLK);
   endtask

   task automatic wait_idle(input int max_cycles, input string name);
      int n;
      n = 0;
      while (busy === 1'b1 && n < max_cycles) begin
         @(negedge CLK);
         n++;
      end
      repeat (3) @(negedge CLK);
      check(name, {63'd0, busy}, 64'd0);
   endtask

   // Monitor: start bit seen at offset 0, mid-bit samples at offsets 4k+2.
   initial begin : monitor
      logic [7:0] b;
      logic       framing_ok;
      logic       aborted;
      logic [7:0] exp;
      forever begin
         @(negedge CLK);
         if (rst === 1'b1 && tx === 1'b0) begin
            b = '0;
            framing_ok = 1'b1;
            aborted = 1'b0;
            for (int k = 1; k < 40; k++) begin
               @(negedge CLK);
               if (rst !== 1'b1) begin
                  aborted = 1'b1;
                  break;
               end
               if (k == 2 && tx !== 1'b0) framing_ok = 1'b0;
               if (k >= 6 && k <= 34 && (k % 4) == 2) b[(k - 6) / 4] = tx;
               if (k == 38 && tx !== 1'b1) framing_ok = 1'b0;
            end
            if (!aborted) begin
               check("frame_expected", {63'd0, exp_q.size() != 0}, 64'd1);
               if (exp_q.size() != 0) begin
                  exp = exp_q.pop_front();
                  check("frame_byte", {56'd0, b}, {56'd0, exp});
                  check("frame_start_stop", {63'd0, framing_ok}, 64'd1);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin : stimulus
      int            n;
      int            peak;
      logic [39:0]   obs;
      logic [39:0]   exp_tx;
      int            frame_bits[10];
      logic [7:0]    bytes3[3];
      logic [7:0]    bytes6[6];

      // 1: reset with capture asserted
      rst = 1'b0;
      capture = 1'b1;
      alu_out = 8'hAA;
      @(negedge CLK);
      @(negedge CLK);
      check("rst_tx", {63'd0, tx}, 64'd1);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_count", {61'd0, fifo_count}, 64'd0);
      check("rst_overflow", {63'd0, overflow}, 64'd0);
      rst = 1'b1;
      capture = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_idle_tx", {63'd0, tx}, 64'd1);
      check("rst_idle_busy", {63'd0, busy}, 64'd0);

      // 2: single frame 8'h45
      frame_bits = '{0, 1, 0, 1, 0, 0, 0, 1, 0, 1};
      for (int k = 0; k < 40; k++) exp_tx[k] = frame_bits[k / 4][0];
      alu_out = 8'h45;
      capture = 1'b1;
      exp_q.push_back(8'h45);
      @(negedge CLK);
      capture = 1'b0;
      alu_out = 8'h00;
      n = (busy === 1'b1) ? 1 : 0;
      check("single_count", {61'd0, fifo_count}, 64'd1);
      for (int k = 0; k < 40; k++) begin
         @(negedge CLK);
         obs[k] = tx;
         if (busy === 1'b1) n++;
      end
      while (busy === 1'b1 && n < 100) begin
         @(negedge CLK);
         if (busy === 1'b1) n++;
      end
      check("single_tx_wave", {24'd0, obs}, {24'd0, exp_tx});
      check("single_busy_cycles", n, 41);

      // 3: back-to-back frames
      bytes3 = '{8'h01, 8'h82, 8'hC3};
      n = 0;
      peak = 0;
      for (int i = 0; i < 3; i++) begin
         alu_out = bytes3[i];
         capture = 1'b1;
         exp_q.push_back(bytes3[i]);
         @(negedge CLK);
         if (busy === 1'b1) n++;
         if (int'(fifo_count) > peak) peak = int'(fifo_count);
      end
      capture = 1'b0;
      while (busy === 1'b1 && n < 400) begin
         @(negedge CLK);
         if (busy === 1'b1) n++;
         if (int'(fifo_count) > peak) peak = int'(fifo_count);
      end
      check("b2b_peak_count", peak, 2);
      check("b2b_busy_cycles", n, 121);

      // 4: overflow on the 6th consecutive capture
      bytes6 = '{8'h11, 8'h52, 8'h93, 8'hD4, 8'h25, 8'h66};
      for (int i = 0; i < 6; i++) begin
         alu_out = bytes6[i];
         capture = 1'b1;
         if (i < 5) exp_q.push_back(bytes6[i]);
         @(negedge CLK);
         if (i == 4) begin
            check("ovf_count_full", {61'd0, fifo_count}, 64'd4);
            check("ovf_before", {63'd0, overflow}, 64'd0);
         end
         if (i == 5) begin
            check("ovf_set", {63'd0, overflow}, 64'd1);
            check("ovf_count_held", {61'd0, fifo_count}, 64'd4);
         end
      end
      capture = 1'b0;
      wait_idle(400, "ovf_drain");
      check("ovf_sticky", {63'd0, overflow}, 64'd1);
      check("ovf_queue_empty", exp_q.size(), 0);

      // 5: capture into a full FIFO on the final STOP cycle
      do_reset();
      check("full_pp_ovf_cleared", {63'd0, overflow}, 64'd0);
      for (int i = 0; i < 5; i++) begin
         alu_out = bytes6[i] ^ 8'hFF;
         capture = 1'b1;
         exp_q.push_back(bytes6[i] ^ 8'hFF);
         @(negedge CLK);
      end
      capture = 1'b0;
      repeat (36) @(negedge CLK);
      check("full_pp_count_before", {61'd0, fifo_count}, 64'd4);
      alu_out = 8'h5A;
      capture = 1'b1;
      exp_q.push_back(8'h5A);
      @(negedge CLK);
      capture = 1'b0;
      check("full_pp_count_after", {61'd0, fifo_count}, 64'd4);
      check("full_pp_overflow", {63'd0, overflow}, 64'd0);
      wait_idle(400, "full_pp_drain");
      check("full_pp_queue_empty", exp_q.size(), 0);

      // 6: reset during DATA bit 3 with two bytes queued
      do_reset();
      for (int i = 0; i < 3; i++) begin
         alu_out = bytes3[i] ^ 8'h3C;
         capture = 1'b1;
         exp_q.push_back(bytes3[i] ^ 8'h3C);
         @(negedge CLK);
      end
      capture = 1'b0;
      repeat (16) @(negedge CLK);
      check("midrst_count_before", {61'd0, fifo_count}, 64'd2);
      rst = 1'b0;
      @(negedge CLK);
      check("midrst_tx", {63'd0, tx}, 64'd1);
      check("midrst_count", {61'd0, fifo_count}, 64'd0);
      @(negedge CLK);
      rst = 1'b1;
      exp_q.delete();
      repeat (8) @(negedge CLK);
      check("midrst_after_tx", {63'd0, tx}, 64'd1);
      check("midrst_after_busy", {63'd0, busy}, 64'd0);

      repeat (4) @(negedge CLK);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
